// File: rtl/ram_access_ctrl.sv
// Request/response front end for the 64x16 single-port data RAM.
// Issues one-cycle RAM commands, absorbs the 1-cycle read latency, optionally zero-fills after reset.
module ram_access_ctrl #(
    parameter int unsigned        ADDR_W        = 6,
    parameter int unsigned        DATA_W        = 16,
    parameter bit                 INIT_ON_RESET = 1'b1,
    parameter logic [DATA_W-1:0]  INIT_VALUE    = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              init_done,
    output logic [ADDR_W-1:0] ram_add,
    output logic [DATA_W-1:0] ram_data_in,
    output logic              ram_r_w,
    output logic              ram_enable,
    output logic              ram_ce,
    input  logic [DATA_W-1:0] ram_data_out
);

    typedef enum logic [1:0] {INIT, IDLE, RD_WAIT, RSP} state_t;

    localparam state_t RST_STATE = INIT_ON_RESET ? INIT : IDLE;

    state_t            state;
    logic [ADDR_W:0]   init_cnt;
    logic [ADDR_W:0]   init_next;
    logic              accept;

    assign init_next = init_cnt + (ADDR_W+1)'(1);

    always_comb begin
        req_ready   = rst_n && ((state == IDLE) || ((state == RSP) && rsp_ready));
        accept      = req_valid && req_ready;
        ram_add     = '0;
        ram_data_in = '0;
        ram_r_w     = 1'b0;
        ram_enable  = 1'b0;
        ram_ce      = 1'b0;
        // Gating on rst_n keeps the RAM quiet even though reset parks the FSM in INIT.
        if (rst_n) begin
            if (state == INIT) begin
                ram_add     = init_cnt[ADDR_W-1:0];
                ram_data_in = INIT_VALUE;
                ram_r_w     = 1'b1;
                ram_enable  = 1'b1;
                ram_ce      = 1'b1;
            end else if (accept) begin
                ram_add     = req_addr;
                ram_data_in = req_wdata;
                ram_r_w     = req_we;
                ram_enable  = 1'b1;
                ram_ce      = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RST_STATE;
            init_cnt  <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            init_done <= !INIT_ON_RESET;
        end else begin
            case (state)
                INIT: begin
                    init_cnt <= init_next;
                    if (init_next[ADDR_W]) begin
                        state     <= IDLE;
                        init_done <= 1'b1;
                    end
                end
                IDLE: begin
                    if (accept && !req_we) state <= RD_WAIT;
                end
                RD_WAIT: begin
                    rsp_rdata <= ram_data_out;
                    rsp_valid <= 1'b1;
                    state     <= RSP;
                end
                RSP: begin
                    // A back-to-back request can only be accepted on the handshake cycle.
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= (accept && !req_we) ? RD_WAIT : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
